// File: rtl/egress_pkg.sv
// Shared constants for the egress collector: Avalon address map,
// status word field offsets and drop counter width.
package egress_pkg;

    localparam logic [3:0] ADDR_Q1     = 4'h1;
    localparam logic [3:0] ADDR_Q2     = 4'h2;
    localparam logic [3:0] ADDR_Q3     = 4'h3;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_DROP1  = 4'h5;
    localparam logic [3:0] ADDR_DROP2  = 4'h6;
    localparam logic [3:0] ADDR_DROP3  = 4'h7;

    localparam int STAT_CNT1  = 0;
    localparam int STAT_CNT2  = 8;
    localparam int STAT_CNT3  = 16;
    localparam int STAT_EMPTY = 24;
    localparam int STAT_FULL  = 27;
    localparam int STAT_CNT_W = 8;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/egress_queue.sv
// One output-port circular queue with pop-gated room and a drop counter.
// Counter logic exists only when EGRESS_DROP_CNT_EN is defined.
module egress_queue
    import egress_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_req,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop_req,
    input  logic                  drop_clr,
    output logic [CW-1:0]         count,
    output logic [DATA_W-1:0]     head,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop;
    logic              room;
    logic              push;
    logic              drop;

    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign pop  = pop_req && (count != '0);
    assign room = (count != CW'(DEPTH)) || pop;
    assign push = push_req && room;
    assign drop = push_req && !room;
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef EGRESS_DROP_CNT_EN
    // A drop coinciding with the clearing read is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop ^ drop_clr;
    assign drop_cnt    = '0;
`endif

endmodule

// File: rtl/egress_collector.sv
// Three-port egress queue collector with Avalon read-side access.
// Define EGRESS_DROP_CNT_EN to build the per-port drop counters.
module egress_collector
    import egress_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] result1,
    input  logic [DATA_W-1:0] result2,
    input  logic [DATA_W-1:0] result3,
    input  logic [2:0]        res_valid,
    input  logic              chipselect,
    input  logic              read,
    input  logic [3:0]        address,
    output logic [DATA_W-1:0] readdata,
    output logic [2:0]        full,
    output logic              egress_irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                  rd_acc;
    logic [2:0]            sel_q;
    logic [2:0]            sel_d;
    logic                  sel_s;
    logic [DATA_W-1:0]     res      [3];
    logic [CW-1:0]         count    [3];
    logic [DATA_W-1:0]     head     [3];
    logic [DROP_CNT_W-1:0] drop_cnt [3];
    logic [2:0]            empty;
    logic [2:0]            qfull;
    logic [31:0]           status;
    logic [DATA_W-1:0]     rd_next;

    assign rd_acc = chipselect && read;
    assign sel_q  = {address == ADDR_Q3, address == ADDR_Q2, address == ADDR_Q1};
    assign sel_d  = {address == ADDR_DROP3, address == ADDR_DROP2,
                     address == ADDR_DROP1};
    assign sel_s  = (address == ADDR_STATUS);

    assign res[0] = result1;
    assign res[1] = result2;
    assign res[2] = result3;

    for (genvar i = 0; i < 3; i++) begin : g_q
        egress_queue #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_q (
            .clk       (clk),
            .reset     (reset),
            .push_req  (res_valid[i]),
            .push_data (res[i]),
            .pop_req   (rd_acc && sel_q[i]),
            .drop_clr  (rd_acc && sel_d[i]),
            .count     (count[i]),
            .head      (head[i]),
            .drop_cnt  (drop_cnt[i])
        );
        assign empty[i] = (count[i] == '0);
        assign qfull[i] = (count[i] == CW'(DEPTH));
    end

    always_comb begin
        status = '0;
        status[STAT_CNT1 +: STAT_CNT_W] = STAT_CNT_W'(count[0]);
        status[STAT_CNT2 +: STAT_CNT_W] = STAT_CNT_W'(count[1]);
        status[STAT_CNT3 +: STAT_CNT_W] = STAT_CNT_W'(count[2]);
        status[STAT_EMPTY +: 3]         = empty;
        status[STAT_FULL +: 3]          = qfull;
    end

    always_comb begin
        rd_next = '0;
        unique case (1'b1)
            sel_q[0]: rd_next = empty[0] ? '0 : head[0];
            sel_q[1]: rd_next = empty[1] ? '0 : head[1];
            sel_q[2]: rd_next = empty[2] ? '0 : head[2];
            sel_s:    rd_next = DATA_W'(status);
            sel_d[0]: rd_next = DATA_W'(drop_cnt[0]);
            sel_d[1]: rd_next = DATA_W'(drop_cnt[1]);
            sel_d[2]: rd_next = DATA_W'(drop_cnt[2]);
            default:  rd_next = '0;
        endcase
    end

    // full and irq lag the queue counts by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata   <= '0;
            full       <= '0;
            egress_irq <= 1'b0;
        end else begin
            if (rd_acc) readdata <= rd_next;
            full       <= qfull;
            egress_irq <= ~&empty;
        end
    end

endmodule

// File: tb/tb_egress_collector.sv
// Directed self-checking bench for egress_collector (DEPTH=8, DATA_W=32).
module tb_egress_collector;

`ifdef EGRESS_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] result1, result2, result3;
    logic [2:0]  res_valid;
    logic        chipselect, read;
    logic [3:0]  address;
    logic [31:0] readdata;
    logic [2:0]  full;
    logic        egress_irq;

    int checks = 0;
    int errors = 0;

    egress_collector #(.DEPTH(8), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .result1    (result1),
        .result2    (result2),
        .result3    (result3),
        .res_valid  (res_valid),
        .chipselect (chipselect),
        .read       (read),
        .address    (address),
        .readdata   (readdata),
        .full       (full),
        .egress_irq (egress_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic [2:0] v, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input logic rd, input logic [3:0] a);
        res_valid  = v;
        result1    = d1;
        result2    = d2;
        result3    = d3;
        chipselect = rd;
        read       = rd;
        address    = a;
        @(posedge clk);
        #1;
        res_valid  = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        address    = '0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        step(3'b000, 0, 0, 0, 1'b1, a);
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_readdata: got %h expected 0", readdata);
        end
        checks++;
        if (full !== 3'b000 || egress_irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags: full=%b irq=%b expected 000/0", full, egress_irq);
        end
        reset = 1'b0;
        rd(4'h4, d);
        checks++;
        if (d !== 32'h0700_0000) begin
            errors++;
            $display("FAIL rst_status: got %h expected 07000000", d);
        end
        rd(4'hF, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_addr: got %h expected 0", d);
        end
    endtask

    task automatic test_port1();
        logic [31:0] d;
        step(3'b001, 32'hA1, 0, 0, 1'b0, 0);
        step(3'b001, 32'hA2, 0, 0, 1'b0, 0);
        checks++;
        if (egress_irq !== 1'b1 || full !== 3'b000) begin
            errors++;
            $display("FAIL p1_irq_up: irq=%b full=%b expected 1/000", egress_irq, full);
        end
        rd(4'h1, d);
        checks++;
        if (d !== 32'hA1) begin
            errors++;
            $display("FAIL p1_pop0: got %h expected 000000a1", d);
        end
        rd(4'h1, d);
        checks++;
        if (d !== 32'hA2) begin
            errors++;
            $display("FAIL p1_pop1: got %h expected 000000a2", d);
        end
        rd(4'h1, d);
        checks++;
        if (d !== 32'h0 || egress_irq !== 1'b0) begin
            errors++;
            $display("FAIL p1_empty: data=%h irq=%b expected 0/0", d, egress_irq);
        end
        rd(4'h4, d);
        checks++;
        if (d !== 32'h0700_0000) begin
            errors++;
            $display("FAIL p1_status: got %h expected 07000000", d);
        end
    endtask

    task automatic test_drop();
        logic [31:0] d;
        for (int i = 0; i < 9; i++) step(3'b010, 0, 32'h10 + i, 0, 1'b0, 0);
        checks++;
        if (full !== 3'b010) begin
            errors++;
            $display("FAIL p2_full: got %b expected 010", full);
        end
        rd(4'h4, d);
        checks++;
        if (d !== 32'h1500_0800) begin
            errors++;
            $display("FAIL p2_status: got %h expected 15000800", d);
        end
        rd(4'h6, d);
        checks++;
        if (d !== (DROP_EN ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL p2_drop: got %h expected %h", d, DROP_EN ? 32'd1 : 32'd0);
        end
        rd(4'h6, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL p2_drop_clr: got %h expected 0", d);
        end
        for (int i = 0; i < 8; i++) begin
            rd(4'h2, d);
            checks++;
            if (d !== 32'h10 + i) begin
                errors++;
                $display("FAIL p2_drain: got %h expected %h", d, 32'h10 + i);
            end
        end
        checks++;
        if (full !== 3'b000) begin
            errors++;
            $display("FAIL p2_full_clr: got %b expected 000", full);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) step(3'b100, 0, 0, 32'h30 + i, 1'b0, 0);
        step(3'b100, 0, 0, 32'hBEEF, 1'b1, 4'h3);
        checks++;
        if (readdata !== 32'h30) begin
            errors++;
            $display("FAIL p3_pop_full: got %h expected 00000030", readdata);
        end
        rd(4'h4, d);
        checks++;
        if (d !== 32'h2308_0000 || full !== 3'b100) begin
            errors++;
            $display("FAIL p3_status: got %h full=%b expected 23080000/100", d, full);
        end
        rd(4'h7, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL p3_nodrop: got %h expected 0", d);
        end
        for (int i = 1; i < 9; i++) begin
            logic [31:0] e;
            e = (i == 8) ? 32'hBEEF : 32'h30 + i;
            rd(4'h3, d);
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL p3_drain: got %h expected %h", d, e);
            end
        end
        rd(4'h3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL p3_empty: got %h expected 0", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] mq [3][$];
        int          drops [3];
        logic [31:0] dv [3];
        logic [31:0] e, d;
        for (int p = 0; p < 3; p++) drops[p] = 0;
        for (int c = 0; c < 20; c++) begin
            int rp;
            rp = c % 3;
            e  = (mq[rp].size() != 0) ? mq[rp].pop_front() : 32'h0;
            for (int p = 0; p < 3; p++) begin
                dv[p] = {8'(p + 1), 16'h0, 8'(c)};
                if (mq[p].size() < 8) mq[p].push_back(dv[p]);
                else drops[p]++;
            end
            step(3'b111, dv[0], dv[1], dv[2], 1'b1, 4'(rp + 1));
            checks++;
            if (readdata !== e) begin
                errors++;
                $display("FAIL b2b_rd c=%0d: got %h expected %h", c, readdata, e);
            end
        end
        for (int p = 0; p < 3; p++) begin
            int n;
            n = mq[p].size();
            for (int k = 0; k < n; k++) begin
                e = mq[p].pop_front();
                rd(4'(p + 1), d);
                checks++;
                if (d !== e) begin
                    errors++;
                    $display("FAIL b2b_drain p=%0d: got %h expected %h", p + 1, d, e);
                end
            end
            rd(4'(p + 5), d);
            e = DROP_EN ? 32'(drops[p]) : 32'h0;
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL b2b_drops p=%0d: got %h expected %h", p + 1, d, e);
            end
        end
        rd(4'h4, d);
        checks++;
        if (d !== 32'h0700_0000) begin
            errors++;
            $display("FAIL b2b_status: got %h expected 07000000", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        for (int i = 0; i < 9; i++) step(3'b011, 32'h50 + i, 32'h60 + i, 0, 1'b0, 0);
        checks++;
        if (full !== 3'b011 || egress_irq !== 1'b1) begin
            errors++;
            $display("FAIL mid_prefull: full=%b irq=%b expected 011/1", full, egress_irq);
        end
        reset = 1'b1;
        step(3'b111, 32'h1, 32'h2, 32'h3, 1'b1, 4'h1);
        reset = 1'b0;
        checks++;
        if (readdata !== 32'h0 || full !== 3'b000 || egress_irq !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: data=%h full=%b irq=%b expected 0/000/0",
                     readdata, full, egress_irq);
        end
        rd(4'h4, d);
        checks++;
        if (d !== 32'h0700_0000) begin
            errors++;
            $display("FAIL mid_status: got %h expected 07000000", d);
        end
        rd(4'h5, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL mid_drop: got %h expected 0", d);
        end
        rd(4'h1, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL mid_q1: got %h expected 0", d);
        end
    endtask

    initial begin
        reset      = 1'b1;
        result1    = '0;
        result2    = '0;
        result3    = '0;
        res_valid  = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        address    = '0;
        test_reset();
        test_port1();
        test_drop();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
